lisnoc_router_output_arbiter: RTL and testbench



---
 rtl/lisnoc_router_output_arbiter.sv | 134 +++++++++++++
 tb/tb_lisnoc_router_output_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/lisnoc_router_output_arbiter.sv
// Output-side arbiter of a router port: round-robin grant across input route stages,
// holds the grant for a whole packet, and forwards flits through a one-entry output buffer.
//
// state  | meaning
// IDLE   | no packet in flight; any requesting input may win round-robin
// LOCKED | a HEADER was forwarded; only lock_q may be read until its LAST
module lisnoc_router_output_arbiter #(
   parameter int flit_data_width = 32,
   parameter int flit_type_width = 2,
   parameter int num_ports       = 5,
   localparam int flit_width     = flit_data_width + flit_type_width
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [num_ports-1:0]            switch_request,
   input  logic [num_ports*flit_width-1:0] switch_flit,
   output logic [num_ports-1:0]            switch_read,
   output logic [flit_width-1:0]           out_flit,
   output logic                            out_valid,
   input  logic                            out_ready
);

   localparam int port_w = (num_ports > 1) ? $clog2(num_ports) : 1;
   localparam logic [port_w:0] last_port = (port_w+1)'(num_ports - 1);
   localparam logic [flit_type_width-1:0] type_header = flit_type_width'(2'b01);
   localparam logic [flit_type_width-1:0] type_last   = flit_type_width'(2'b10);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                state_q, state_d;
   logic [port_w-1:0]     ptr_q, ptr_d;
   logic [port_w-1:0]     lock_q, lock_d;
   logic [flit_width-1:0] out_flit_q, out_flit_d;
   logic                  out_valid_q, out_valid_d;

   logic                       accept;
   logic [2*num_ports-1:0]     req_rot;
   logic                       found;
   logic [port_w:0]            grant_raw;
   logic [port_w:0]            grant_wrap;
   logic [port_w:0]            grant_inc;
   logic [port_w-1:0]          grant;
   logic [port_w-1:0]          grant_next;
   logic [port_w-1:0]          read_port;
   logic                       sel_req;
   logic [flit_width-1:0]      read_flit;
   logic [flit_type_width-1:0] read_type;
   logic                       do_read;
   logic [num_ports-1:0]       read_vec;

   assign accept = ~out_valid_q | out_ready;

   // Rotating the doubled request vector puts the pointer's port at bit 0, so the
   // lowest set bit is the round-robin winner.
   assign req_rot = {switch_request, switch_request} >> ptr_q;

   always_comb begin
      found     = 1'b0;
      grant_raw = '0;
      for (int k = num_ports - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            found     = 1'b1;
            grant_raw = {1'b0, ptr_q} + (port_w+1)'(k);
         end
      end
      grant_wrap = (grant_raw > last_port) ? grant_raw - (last_port + 1'b1) : grant_raw;
      grant      = grant_wrap[port_w-1:0];
      grant_inc  = {1'b0, grant} + 1'b1;
      grant_next = (grant_inc > last_port) ? '0 : grant_inc[port_w-1:0];
   end

   // The read decision uses only requests and state; the flit mux feeds data only.
   always_comb begin
      read_port = (state_q == LOCKED) ? lock_q : grant;
      sel_req   = 1'b0;
      read_flit = '0;
      for (int i = 0; i < num_ports; i++) begin
         if (port_w'(i) == read_port) begin
            sel_req   = switch_request[i];
            read_flit = switch_flit[i*flit_width +: flit_width];
         end
      end
      read_type = read_flit[flit_width-1 -: flit_type_width];
      do_read   = ~rst & accept & sel_req & ((state_q == LOCKED) | found);
      read_vec  = '0;
      for (int i = 0; i < num_ports; i++) begin
         read_vec[i] = do_read & (port_w'(i) == read_port);
      end
   end

   always_comb begin
      state_d     = state_q;
      lock_d      = lock_q;
      ptr_d       = ptr_q;
      out_flit_d  = out_flit_q;
      out_valid_d = out_valid_q;
      if (do_read) begin
         out_flit_d  = read_flit;
         out_valid_d = 1'b1;
         if (state_q == IDLE) begin
            ptr_d = grant_next;
            if (read_type == type_header) begin
               state_d = LOCKED;
               lock_d  = grant;
            end
         end else if (read_type == type_last) begin
            state_d = IDLE;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         lock_q      <= '0;
         ptr_q       <= '0;
         out_flit_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         lock_q      <= lock_d;
         ptr_q       <= ptr_d;
         out_flit_q  <= out_flit_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign switch_read = read_vec;
   assign out_flit    = out_flit_q;
   assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_lisnoc_router_output_arbiter.sv
// Bench for lisnoc_router_output_arbiter: directed checks of the single-flit and round-robin
// cases, then randomized traffic compared cycle by cycle against a packet-level model.
module tb_lisnoc_router_output_arbiter;

   localparam int N  = 5;
   localparam int DW = 32;
   localparam int TW = 2;
   localparam int FW = DW + TW;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  switch_request;
   logic [N*FW-1:0] switch_flit;
   logic [N-1:0]  switch_read;
   logic [FW-1:0] out_flit;
   logic          out_valid;
   logic          out_ready;

   always #5 clk = ~clk;

   lisnoc_router_output_arbiter #(
      .flit_data_width(DW),
      .flit_type_width(TW),
      .num_ports(N)
   ) dut (
      .clk(clk),
      .rst(rst),
      .switch_request(switch_request),
      .switch_flit(switch_flit),
      .switch_read(switch_read),
      .out_flit(out_flit),
      .out_valid(out_valid),
      .out_ready(out_ready)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: round-robin pointer, packet lock and the output buffer content.
   int            m_ptr;
   int            m_lport;
   bit            m_locked;
   bit            m_valid;
   logic [FW-1:0] m_flit;
   logic [N-1:0]  last_read;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ptr    = 0;
      m_lport  = 0;
      m_locked = 0;
      m_valid  = 0;
      m_flit   = '0;
   endtask

   // Called just after inputs are driven at the negedge; advances one clock.
   task automatic step();
      int            g;
      bit            acc;
      logic [N-1:0]  er;
      logic [FW-1:0] f;
      #1;
      g   = -1;
      acc = !m_valid || out_ready;
      if (!rst && acc) begin
         if (!m_locked) begin
            for (int k = 0; k < N; k++) begin
               if (g < 0 && switch_request[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
         end else if (switch_request[m_lport]) begin
            g = m_lport;
         end
      end
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      check_eq("switch_read", 64'(switch_read), 64'(er));
      last_read = switch_read;
      @(posedge clk);
      #1;
      if (rst) begin
         model_reset();
      end else if (g >= 0) begin
         f       = switch_flit[g*FW +: FW];
         m_flit  = f;
         m_valid = 1;
         if (!m_locked) begin
            m_ptr = (g + 1) % N;
            if (f[FW-1 -: TW] == 2'b01) begin
               m_locked = 1;
               m_lport  = g;
            end
         end else if (f[FW-1 -: TW] == 2'b10) begin
            m_locked = 0;
         end
      end else if (out_ready) begin
         m_valid = 0;
      end
      check_eq("out_valid", 64'(out_valid), 64'(m_valid));
      check_eq("out_flit", 64'(out_flit), 64'(m_flit));
   endtask

   task automatic drive_random(input int dens, input int rdy_pct, input int rst_pm);
      logic [TW-1:0] t;
      logic [DW-1:0] d;
      rst = ($urandom_range(0, 999) < rst_pm);
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      for (int i = 0; i < N; i++) begin
         switch_request[i] = ($urandom_range(0, 99) < dens);
         t = TW'($urandom_range(0, 3));
         d = $urandom;
         switch_flit[i*FW +: FW] = {t, d};
      end
   endtask

   task automatic set_all_single();
      logic [DW-1:0] d;
      for (int i = 0; i < N; i++) begin
         d = $urandom;
         switch_flit[i*FW +: FW] = {2'b11, d};
      end
   endtask

   initial begin
      int dens_tab[6];
      int rdy_tab[6];
      logic [N-1:0] rr_exp[4];
      dens_tab = '{20, 50, 90, 100, 60, 35};
      rdy_tab  = '{100, 70, 30, 100, 50, 90};
      rr_exp   = '{5'b00001, 5'b01000, 5'b00001, 5'b01000};

      rst = 1'b1;
      switch_request = '0;
      switch_flit = '0;
      out_ready = 1'b0;
      model_reset();

      repeat (2) begin
         @(negedge clk);
         switch_request = '1;
         step();
      end

      // Single flit from port 2.
      @(negedge clk);
      rst = 1'b0;
      switch_request = 5'b00100;
      switch_flit = '0;
      switch_flit[2*FW +: FW] = {2'b11, 32'h0000_1234};
      out_ready = 1'b1;
      step();
      check_eq("single_read", 64'(last_read), 64'(5'b00100));
      check_eq("single_flit", 64'(out_flit), 64'(34'h3_0000_1234));
      check_eq("single_valid", 64'(out_valid), 64'd1);

      // Round-robin between ports 0 and 3 from a fresh pointer.
      @(negedge clk);
      rst = 1'b1;
      step();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         rst = 1'b0;
         switch_request = 5'b01001;
         out_ready = 1'b1;
         set_all_single();
         step();
         check_eq("rr_read", 64'(last_read), 64'(rr_exp[c]));
      end

      // Randomized traffic with varying load and backpressure.
      for (int p = 0; p < 6; p++) begin
         for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            drive_random(dens_tab[p], rdy_tab[p], 3);
            step();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
